// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status out.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  // The receiver owns the byte and status outputs.
  modport master (
    input  rxd,
    output data,
    output valid,
    output ferr,
    output busy
  );

  // The line driver / byte consumer side.
  modport slave (
    output rxd,
    input  data,
    input  valid,
    input  ferr,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit centre qualification, mid-bit sampling, and
// single-cycle valid / framing-error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HALF_BIT     = 2604
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam logic [12:0] BitLast  = 13'(CLKS_PER_BIT - 1);
  localparam logic [12:0] HalfLast = 13'(HALF_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic [1:0]  sync_q;
  logic        rxs;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rxd};
    end
  end

  assign rxs = sync_q[1];

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Frame sequencing: next state, baud counter, bit index and pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is high again at the start-bit centre was a glitch.
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rxs;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          // Leave at the stop-bit centre so a back-to-back start edge is caught.
          cnt_d   = '0;
          state_d = StIdle;
          if (rxs) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.ferr  = ferr_q;
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period.
module tb_uart_rx;

  localparam int unsigned Cpb  = 16;
  localparam int unsigned Half = 8;

  logic clk;
  logic rst;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .HALF_BIT    (Half)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cycle = 0;
  int         busy_cycles = 0;
  int         ferr_cnt = 0;
  logic [7:0] vq[$];
  int         vt[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (bus.busy) busy_cycles++;
    if (bus.valid) begin
      vq.push_back(bus.data);
      vt.push_back(cycle);
    end
    if (bus.ferr) ferr_cnt++;
    if (bus.valid || bus.ferr) check("valid_ferr_excl", {31'b0, bus.valid & bus.ferr}, 32'd0);
  end

  task automatic line_bit(input logic b, input int n);
    bus.rxd = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    line_bit(1'b1, n);
  endtask

  // Behavioural transmitter: start, 8 data LSB first, stop.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    line_bit(1'b0, Cpb);
    for (int i = 0; i < 8; i++) line_bit(b[i], Cpb);
    line_bit(stop_bit, Cpb);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (vq.size() != 0) begin
      got = vq.pop_front();
      void'(vt.pop_front());
    end
    check(tag, {24'b0, got}, {24'b0, exp});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'b0, bus.data}, 32'd0);
    check({tag, "_valid"}, {31'b0, bus.valid}, 32'd0);
    check({tag, "_ferr"},  {31'b0, bus.ferr}, 32'd0);
    check({tag, "_busy"},  {31'b0, bus.busy}, 32'd0);
  endtask

  int diff;

  initial begin
    rst     = 1'b0;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(20);

    // Single clean frame.
    send_byte(8'h55, 1'b1);
    idle(4);
    check("f55_count", vq.size(), 32'd1);
    expect_byte("f55_data", 8'h55);
    check("f55_ferr", ferr_cnt, 32'd0);
    check("f55_busy", {31'b0, bus.busy}, 32'd0);

    // Short low glitch: START lasts exactly HALF_BIT cycles, then IDLE.
    busy_cycles = 0;
    line_bit(1'b0, 3);
    idle(40);
    check("glitch_busy_cycles", busy_cycles, Half);
    check("glitch_valid", vq.size(), 32'd0);
    check("glitch_ferr", ferr_cnt, 32'd0);
    check("glitch_busy", {31'b0, bus.busy}, 32'd0);

    // Framing error, then a held-low break that must be received as 0xFF.
    send_byte(8'hA3, 1'b0);
    check("ferr_count", ferr_cnt, 32'd1);
    check("ferr_no_valid", vq.size(), 32'd0);
    check("ferr_data_kept", {24'b0, bus.data}, 32'h55);
    line_bit(1'b0, Half);
    idle(10 * Cpb + 10);
    check("break_count", vq.size(), 32'd1);
    expect_byte("break_data", 8'hFF);
    check("break_ferr", ferr_cnt, 32'd1);

    // Back-to-back frames with no idle gap.
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    check("b2b_count", vq.size(), 32'd2);
    diff = (vt.size() >= 2) ? (vt[1] - vt[0]) : -1;
    check("b2b_spacing", diff, 10 * Cpb);
    expect_byte("b2b_first", 8'h00);
    expect_byte("b2b_second", 8'hFF);

    // Reset during data bit 4 of 0xA5 aborts the frame.
    line_bit(1'b0, Cpb);
    line_bit(1'b1, Cpb);
    line_bit(1'b0, Cpb);
    line_bit(1'b1, Cpb);
    line_bit(1'b0, Cpb);
    line_bit(1'b0, Half);
    rst     = 1'b0;
    bus.rxd = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    idle(2 * Cpb);
    check("midrst_no_valid", vq.size(), 32'd0);
    check("midrst_no_ferr", ferr_cnt, 32'd1);
    send_byte(8'h3C, 1'b1);
    idle(4);
    check("post_rst_count", vq.size(), 32'd1);
    expect_byte("post_rst_data", 8'h3C);

    // Loopback-style stream through the behavioural transmitter.
    send_byte(8'h00, 1'b1);
    idle(Cpb);
    send_byte(8'h7E, 1'b1);
    idle(Cpb);
    send_byte(8'hFF, 1'b1);
    idle(Cpb);
    check("loop_count", vq.size(), 32'd3);
    expect_byte("loop_00", 8'h00);
    expect_byte("loop_7e", 8'h7E);
    expect_byte("loop_ff", 8'hFF);
    check("loop_ferr", ferr_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, meaning clk cycles per bit (50 MHz, 9600 baud).
REQ-002 SHALL have parameter HALF_BIT, default 2604, meaning clk cycles from start-bit falling edge to start-bit centre.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port data  output  8  last received byte.
REQ-007 SHALL have port valid  output  1  one-cycle pulse; data holds a new good byte.
REQ-008 SHALL have port ferr  output  1  one-cycle pulse; stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-010 SHALL pass rxd through a two-flop synchronizer; all logic below uses the synchronized value rxs, which resets to 1.
REQ-011 SHALL frame as 1 start (0), 8 data LSB first, 1 stop (1); no parity.
REQ-012 SHALL implement states IDLE, START, DATA, STOP with a 13-bit baud counter and a 3-bit bit index.
REQ-013 IDLE: counter held at 0; on rxs==0 go to START with counter cleared.
REQ-014 START: counter increments; at counter==HALF_BIT-1, if rxs==0 go to DATA, counter cleared, bit index 0; else return to IDLE (glitch reject, no pulses).
REQ-015 DATA: at counter==CLKS_PER_BIT-1, shift rxs into shift-register bit [bit index], clear counter; after index 7 go to STOP, else increment index.
REQ-016 STOP: at counter==CLKS_PER_BIT-1, sample rxs and go to IDLE.
REQ-017 On the STOP sample with rxs==1, data SHALL load the shift register and valid SHALL pulse high for exactly the next cycle.
REQ-018 On the STOP sample with rxs==0, ferr SHALL pulse for one cycle, valid SHALL stay low, and data SHALL keep its previous value.
REQ-019 valid and ferr SHALL never be high in the same cycle.
REQ-020 Return to IDLE occurs at the stop-bit centre, so a start edge of a back-to-back frame SHALL be detected without loss.
REQ-021 If rxs stays low after a framing error (break), START is re-entered and the frame is processed normally; no lockup.
REQ-022 data SHALL remain stable between valid pulses; there is no handshake and no overrun detection; the consumer must capture data on valid.
REQ-023 The baud counter SHALL never exceed CLKS_PER_BIT-1; wrap to 0 at terminal count.

Reset
REQ-024 rst low SHALL asynchronously force state IDLE, counter 0, bit index 0, shift register 0x00, data 0x00, valid 0, ferr 0, busy 0, synchronizer flops 1.
REQ-025 rst asserted mid-frame SHALL abort the frame with no valid/ferr pulse; after release, reception SHALL resume at the next falling edge of rxs.

Verification
REQ-026 Frame 0x55 (start, 1,0,1,0,1,0,1,0 LSB first, stop=1) at 5208 clk/bit -> exactly one valid pulse, data==0x55, ferr 0, busy low after the stop centre.
REQ-027 Low glitch on rxd of 1000 clk then high -> no valid, no ferr, busy high at most ~HALF_BIT+2 cycles, returns to IDLE.
REQ-028 Frame 0xA3 with stop bit driven 0 -> ferr one pulse, valid 0, data unchanged from the prior value (0x55).
REQ-029 Two back-to-back frames 0x00 then 0xFF with no idle gap -> two valid pulses ~10*5208 cycles apart, data 0x00 then 0xFF.
REQ-030 rst pulsed low during data bit 4 of a frame, then a clean 0x3C frame -> no pulse for the aborted frame, all outputs at reset values during rst, then valid with data==0x3C.
REQ-031 Loopback with the existing transmitter (txd->rxd) sending 0x00, 0x7E, 0xFF -> each byte reproduced with one valid pulse, no ferr.
